// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared state encoding and default widths for the pattern detector
package seq_det_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int DEF_PAT_W = 4;
  localparam int DEF_CNT_W = 8;
  typedef enum logic [1:0] {ST_IDLE = IDLE, ST_RUN = RUN, ST_DONE = DONE} state_e;
endpackage

// File: rtl/seq_det_ctrl_shift.sv
// pattern_shift_det: serial history with fill tracking; flags a hit for the bit being shifted in
module pattern_shift_det
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             shift_en_i,
  input  logic             din_i,
  input  logic [PAT_W-1:0] pattern_i,
  output logic             hit_o
);
  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);
  localparam logic [FW-1:0] NEED = FW'(PAT_W - 1);
  logic [PAT_W-2:0] hist_q;
  logic [FW-1:0]    fill_q;
  logic [PAT_W-1:0] window;
  assign window = {hist_q, din_i};
  assign hit_o  = (fill_q >= NEED) && (window == pattern_i);
  // history only moves on qualified bits; fill saturates once the window is full
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (shift_en_i) begin
      hist_q <= window[PAT_W-2:0];
      fill_q <= (fill_q < FULL) ? fill_q + 1'b1 : fill_q;
    end
  end
endmodule

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: configurable overlapping serial pattern counter with run/done sequencing
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             abort,
  input  logic             din,
  input  logic             din_valid,
  output logic             busy,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_count,
  output logic             done,
  output logic             err_cfg
);
  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] tgt_q, tgt_d, cnt_q, cnt_d, cnt_inc;
  logic             pulse_q, pulse_d, err_q, err_d;
  logic             in_run, shift_en, hit, match, start_ok;
  assign in_run   = (state_q == ST_RUN);
  assign start_ok = start && !in_run;
  assign shift_en = in_run && din_valid && !abort;
  assign match    = shift_en && hit;
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  pattern_shift_det #(.PAT_W(PAT_W)) u_det (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (start_ok),
    .shift_en_i(shift_en),
    .din_i     (din),
    .pattern_i (pat_q),
    .hit_o     (hit)
  );
  // sequencing: config/start accepted outside RUN; in RUN abort beats a match, target ends the run
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    err_d   = 1'b0;
    if (in_run) begin
      err_d = cfg_we;
      if (abort) state_d = ST_IDLE;
      else if (match) begin
        pulse_d = 1'b1;
        cnt_d   = cnt_inc;
        state_d = (tgt_q != '0 && cnt_inc == tgt_q) ? ST_DONE : ST_RUN;
      end
    end else begin
      if (cfg_we) begin
        pat_d   = cfg_pattern;
        tgt_d   = cfg_target;
        state_d = ST_IDLE;
      end
      if (start) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    end
  end
  // state, configuration and registered output pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      err_q   <= err_d;
    end
  end
  assign busy        = in_run;
  assign done        = (state_q == ST_DONE);
  assign match_pulse = pulse_q;
  assign match_count = cnt_q;
  assign err_cfg     = err_q;
endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: table-driven and directed checks of the serial pattern controller
module tb_seq_det_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_pattern = '0;
  logic [7:0] cfg_target = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       busy, match_pulse, done, err_cfg;
  logic [7:0] match_count;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic       we;
    logic [3:0] pat;
    logic [7:0] tgt;
    logic       st, ab, d, dv;
    logic       e_busy, e_pulse;
    logic [7:0] e_cnt;
    logic       e_done, e_err;
  } vec_t;
  vec_t tbl[64];
  int   n = 0;

  seq_det_ctrl #(.PAT_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_target(cfg_target), .start(start), .abort(abort), .din(din),
    .din_valid(din_valid), .busy(busy), .match_pulse(match_pulse),
    .match_count(match_count), .done(done), .err_cfg(err_cfg)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic we, input logic [3:0] pat, input logic [7:0] tgt,
                       input logic st, input logic ab, input logic d, input logic dv);
    cfg_we = we; cfg_pattern = pat; cfg_target = tgt;
    start = st; abort = ab; din = d; din_valid = dv;
    @(posedge clk);
    #1;
  endtask

  task automatic one(input string nm, input string f, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s %s: got %0d want %0d", nm, f, act, exp);
    end
  endtask

  task automatic chk(input string nm, input logic b, input logic p, input logic [7:0] c,
                     input logic dn, input logic e);
    one(nm, "busy", {7'd0, busy}, {7'd0, b});
    one(nm, "match_pulse", {7'd0, match_pulse}, {7'd0, p});
    one(nm, "match_count", match_count, c);
    one(nm, "done", {7'd0, done}, {7'd0, dn});
    one(nm, "err_cfg", {7'd0, err_cfg}, {7'd0, e});
  endtask

  task automatic add(input logic we, input logic [3:0] pat, input logic [7:0] tgt,
                     input logic st, input logic ab, input logic d, input logic dv,
                     input logic eb, input logic ep, input logic [7:0] ec,
                     input logic ed, input logic ee);
    tbl[n] = '{we, pat, tgt, st, ab, d, dv, eb, ep, ec, ed, ee};
    n++;
  endtask

  initial begin
    // overlap run: pattern 0110, target 2, bits 0110110
    add(1, 4'b0110, 8'd2, 1, 0, 0, 0,  1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1,  1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1,  1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1,  1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1,  1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  0, 1, 2, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0,  0, 0, 2, 1, 0);
    // same stream with invalid gaps carrying toggling din
    add(0, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1,  1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1,  1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1,  1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1,  1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  0, 1, 2, 1, 0);
    // config write during RUN is rejected
    add(0, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0);
    add(1, 4'b1111, 8'd0, 0, 0, 0, 1,  1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1,  1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1,  1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1,  1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1,  1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1,  1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1,  1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,  0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,  0, 0, 1, 0, 0);

    // reset held with start and cfg_we asserted
    rst_n = 1'b0;
    drive(1, 4'b1111, 8'd1, 1, 0, 1, 1);
    drive(1, 4'b1111, 8'd1, 1, 0, 1, 1);
    chk("reset", 0, 0, 8'd0, 0, 0);
    rst_n = 1'b1;
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("post_reset_start", 1, 0, 8'd0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 1, 1);
      chk("reset_cfg_zero", 1, 0, 8'd0, 0, 0);
    end
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("reset_abort", 0, 0, 8'd0, 0, 0);

    for (int i = 0; i < n; i++) begin
      drive(tbl[i].we, tbl[i].pat, tbl[i].tgt, tbl[i].st, tbl[i].ab, tbl[i].d, tbl[i].dv);
      chk($sformatf("vec%0d", i), tbl[i].e_busy, tbl[i].e_pulse, tbl[i].e_cnt, tbl[i].e_done, tbl[i].e_err);
    end

    // abort on the edge that samples the final pattern bit
    drive(1, 4'b0110, 8'd2, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 1, 1);
    chk("abort_pre", 1, 0, 8'd0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 1);
    chk("abort_hit", 0, 0, 8'd0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("abort_after", 0, 0, 8'd0, 0, 0);

    // unlimited target: ten ones against 1111, then reset mid-stream
    drive(1, 4'b1111, 8'd0, 1, 0, 0, 0);
    chk("unl_start", 1, 0, 8'd0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 0, 1, 1);
      chk($sformatf("unl_bit%0d", i + 1), 1, (i >= 3), (i >= 3) ? 8'(i - 2) : 8'd0, 0, 0);
    end
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 1, 1);
    chk("unl_reset", 0, 0, 8'd0, 0, 0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 1);
    chk("unl_after_reset", 0, 0, 8'd0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
